// File: rtl/binary_div_8_4_uni_pkg.sv
// Shared definitions for the 8/4 unsigned restoring divider.
package binary_div_8_4_uni_pkg;

  localparam int unsigned DIV_N_W = 8;
  localparam int unsigned DIV_D_W = 4;
  localparam int unsigned LATENCY = DIV_N_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/binary_div_8_4_uni_step.sv
// One restoring-division step: shift in a dividend bit, subtract D if it fits.
module binary_div_step #(
  parameter int unsigned D_W = 4
) (
  input  logic [D_W-1:0] i_rem,
  input  logic           i_bit,
  input  logic [D_W-1:0] i_d,
  output logic [D_W-1:0] o_rem,
  output logic           o_q_bit
);

  logic [D_W:0] w_t;
  logic [D_W:0] w_diff;

  // The kept remainder is always < D (or the raw trial value), so it fits D_W bits.
  always_comb begin
    w_t     = {i_rem, i_bit};
    w_diff  = w_t - {1'b0, i_d};
    o_q_bit = (w_t >= {1'b0, i_d});
    o_rem   = D_W'(o_q_bit ? w_diff : w_t);
  end

endmodule

// File: rtl/binary_div_8_4_uni.sv
// Sequential unsigned restoring divider, one quotient bit per enabled cycle.
module binary_div_8_4_uni
  import binary_div_8_4_uni_pkg::*;
#(
  parameter int unsigned N_W = DIV_N_W,
  parameter int unsigned D_W = DIV_D_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           start,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero
);

  localparam int unsigned CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

  state_t         r_state;
  state_t         w_next;
  logic [N_W-1:0] r_shift;
  logic [N_W-1:0] r_q;
  logic [D_W-1:0] r_rem;
  logic [D_W-1:0] r_d;
  logic [D_W-1:0] r_n_lo;
  logic [D_W-1:0] r_r;
  logic [CNT_W-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic           w_accept;
  logic           w_step;
  logic           w_finish;
  logic           w_last;
  logic [D_W-1:0] w_rem_nxt;
  logic           w_qbit;

  binary_div_step #(.D_W(D_W)) u_step (
    .i_rem   (r_rem),
    .i_bit   (r_shift[N_W-1]),
    .i_d     (r_d),
    .o_rem   (w_rem_nxt),
    .o_q_bit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)  r_state <= IDLE;
    else if (en) r_state <= w_next;
  end

  always_comb begin
    w_last = (r_cnt == CNT_W'(N_W - 1));
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) && start;
    w_step   = (r_state == CALC);
    w_finish = (r_state == DONE);
  end

  // Quotient bits replace dividend bits in the same shift register as they are consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_rem   <= '0;
      r_d     <= '0;
      r_n_lo  <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (en) begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_d     <= D;
        r_n_lo  <= N[D_W-1:0];
        r_rem   <= '0;
        r_shift <= N;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end
      if (w_step) begin
        r_rem   <= w_rem_nxt;
        r_shift <= {r_shift[N_W-2:0], w_qbit};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        if (r_d == '0) begin
          r_q   <= '1;
          r_r   <= r_n_lo;
          r_dbz <= 1'b1;
        end else begin
          r_q   <= r_shift;
          r_r   <= r_rem;
          r_dbz <= 1'b0;
        end
      end
    end
  end

  assign Q           = r_q;
  assign R           = r_r;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
